// File: rtl/bp_resolve_queue.sv
// In-order queue of branch predictions between fetch and execute. Execute resolves the oldest entry;
// mispredicts flush the queue and redirect fetch. Training feedback and saturating stats are registered.
module bp_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [31:0]      push_pc_i,
  input  logic             push_taken_i,
  input  logic [31:0]      push_target_i,
  input  logic             res_valid_i,
  input  logic [31:0]      res_pc_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  input  logic             res_compressed_i,
  output logic             mispredict_o,
  output logic [31:0]      redirect_pc_o,
  output logic [31:0]      ex_br_instr_addr_o,
  output logic             ex_br_taken_o,
  output logic             ex_br_valid_o,
  output logic             res_err_o,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispredicts_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] fall_through(input logic [31:0] pc, input logic comp);
    return pc + (comp ? 32'd2 : 32'd4);
  endfunction

  logic [31:0]      pc_mem_q     [DEPTH];
  logic [31:0]      pc_mem_d     [DEPTH];
  logic [31:0]      target_mem_q [DEPTH];
  logic [31:0]      target_mem_d [DEPTH];
  logic             taken_mem_q  [DEPTH];
  logic             taken_mem_d  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [31:0]      ex_addr_q, ex_addr_d;
  logic             ex_taken_q, ex_taken_d;
  logic             ex_valid_q, ex_valid_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

  logic             empty, full;
  logic             push_acc, res_acc, res_rej, mispred;
  logic [31:0]      head_pc, head_target;
  logic             head_taken;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == FULL_CNT);
  assign head_pc     = pc_mem_q[rd_ptr_q];
  assign head_target = target_mem_q[rd_ptr_q];
  assign head_taken  = taken_mem_q[rd_ptr_q];

  // No bypass: a full queue refuses a push even when the head pops this cycle.
  assign push_ready_o = !full & !mispredict_q;
  assign push_acc     = push_valid_i & push_ready_o;
  assign res_acc      = res_valid_i & !empty & (res_pc_i == head_pc);
  assign res_rej      = res_valid_i & !res_acc;
  assign mispred      = res_acc & ((res_taken_i != head_taken) |
                                   (res_taken_i & head_taken & (res_target_i != head_target)));

  always_comb begin
    pc_mem_d     = pc_mem_q;
    target_mem_d = target_mem_q;
    taken_mem_d  = taken_mem_q;
    if (push_acc) begin
      pc_mem_d[wr_ptr_q]     = push_pc_i;
      target_mem_d[wr_ptr_q] = push_target_i;
      taken_mem_d[wr_ptr_q]  = push_taken_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (mispred) begin
      // Every younger entry is wrong-path, and so is any push arriving this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (res_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + (PTR_W+1)'(push_acc) - (PTR_W+1)'(res_acc);
    end
  end

  always_comb begin
    mispredict_d  = mispred;
    redirect_pc_d = redirect_pc_q;
    ex_valid_d    = res_acc;
    ex_addr_d     = ex_addr_q;
    ex_taken_d    = ex_taken_q;
    res_err_d     = res_rej;
    stat_br_d     = stat_br_q;
    stat_mp_d     = stat_mp_q;
    if (res_acc) begin
      ex_addr_d  = res_pc_i;
      ex_taken_d = res_taken_i;
      stat_br_d  = sat_inc(stat_br_q);
    end
    if (mispred) begin
      redirect_pc_d = res_taken_i ? res_target_i : fall_through(res_pc_i, res_compressed_i);
      stat_mp_d     = sat_inc(stat_mp_q);
    end
  end

  always_ff @(posedge clk_i) begin
    pc_mem_q     <= pc_mem_d;
    target_mem_q <= target_mem_d;
    taken_mem_q  <= taken_mem_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      ex_addr_q     <= '0;
      ex_taken_q    <= 1'b0;
      ex_valid_q    <= 1'b0;
      res_err_q     <= 1'b0;
      stat_br_q     <= '0;
      stat_mp_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      ex_addr_q     <= ex_addr_d;
      ex_taken_q    <= ex_taken_d;
      ex_valid_q    <= ex_valid_d;
      res_err_q     <= res_err_d;
      stat_br_q     <= stat_br_d;
      stat_mp_q     <= stat_mp_d;
    end
  end

  assign mispredict_o       = mispredict_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign ex_br_instr_addr_o = ex_addr_q;
  assign ex_br_taken_o      = ex_taken_q;
  assign ex_br_valid_o      = ex_valid_q;
  assign res_err_o          = res_err_q;
  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Bench for bp_resolve_queue: table of {stimulus, expected} records run through a scoreboard queue,
// followed by hand-written reset and counter-saturation sequences.
module tb_bp_resolve_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             push_valid_i, push_ready_o, push_taken_i;
  logic [31:0]      push_pc_i, push_target_i;
  logic             res_valid_i, res_taken_i, res_compressed_i;
  logic [31:0]      res_pc_i, res_target_i;
  logic             mispredict_o, ex_br_taken_o, ex_br_valid_o, res_err_o;
  logic [31:0]      redirect_pc_o, ex_br_instr_addr_o;
  logic [CNT_W-1:0] stat_branches_o, stat_mispredicts_o;

  always #5 clk_i = ~clk_i;

  bp_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
    .push_taken_i(push_taken_i), .push_target_i(push_target_i),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_target_i(res_target_i), .res_compressed_i(res_compressed_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .ex_br_instr_addr_o(ex_br_instr_addr_o), .ex_br_taken_o(ex_br_taken_o),
    .ex_br_valid_o(ex_br_valid_o), .res_err_o(res_err_o),
    .stat_branches_o(stat_branches_o), .stat_mispredicts_o(stat_mispredicts_o)
  );

  typedef struct {
    logic        pv;  logic [31:0] ppc; logic pt; logic [31:0] ptg;
    logic        rv;  logic [31:0] rpc; logic rt; logic [31:0] rtg; logic rc;
    logic        e_rdy; logic e_mp; logic [31:0] e_redir;
    logic        e_exv; logic [31:0] e_exa; logic e_ext; logic e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   nvec  = 0;
  int   nfail = 0;
  logic [CNT_W-1:0] exp_br, exp_mp;

  function automatic vec_t V(input logic [31:0] pv, ppc, pt, ptg, rv, rpc, rt, rtg, rc,
                             input logic [31:0] rdy, mp, redir, exv, exa, ext, err);
    vec_t v;
    v.pv = pv[0]; v.ppc = ppc; v.pt = pt[0]; v.ptg = ptg;
    v.rv = rv[0]; v.rpc = rpc; v.rt = rt[0]; v.rtg = rtg; v.rc = rc[0];
    v.e_rdy = rdy[0]; v.e_mp = mp[0]; v.e_redir = redir;
    v.e_exv = exv[0]; v.e_exa = exa; v.e_ext = ext[0]; v.e_err = err[0];
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    push_valid_i = 1'b0; push_pc_i = '0; push_taken_i = 1'b0; push_target_i = '0;
    res_valid_i = 1'b0; res_pc_i = '0; res_taken_i = 1'b0; res_target_i = '0;
    res_compressed_i = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk_i);
    push_valid_i = v.pv; push_pc_i = v.ppc; push_taken_i = v.pt; push_target_i = v.ptg;
    res_valid_i = v.rv; res_pc_i = v.rpc; res_taken_i = v.rt; res_target_i = v.rtg;
    res_compressed_i = v.rc;
    #1;
    chk("push_ready", 32'(push_ready_o), 32'(v.e_rdy));
    sb.push_back(v);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    if (e.e_exv) exp_br = sat(exp_br);
    if (e.e_mp)  exp_mp = sat(exp_mp);
    chk("mispredict", 32'(mispredict_o), 32'(e.e_mp));
    chk("res_err", 32'(res_err_o), 32'(e.e_err));
    chk("ex_valid", 32'(ex_br_valid_o), 32'(e.e_exv));
    if (e.e_mp) chk("redirect_pc", redirect_pc_o, e.e_redir);
    if (e.e_exv) begin
      chk("ex_addr", ex_br_instr_addr_o, e.e_exa);
      chk("ex_taken", 32'(ex_br_taken_o), 32'(e.e_ext));
    end
    chk("stat_branches", 32'(stat_branches_o), 32'(exp_br));
    chk("stat_mispredicts", 32'(stat_mispredicts_o), 32'(exp_mp));
  endtask

  task automatic chk_reset_state();
    chk("rst_push_ready", 32'(push_ready_o), 32'd1);
    chk("rst_mispredict", 32'(mispredict_o), 32'd0);
    chk("rst_redirect", redirect_pc_o, 32'd0);
    chk("rst_ex_valid", 32'(ex_br_valid_o), 32'd0);
    chk("rst_ex_addr", ex_br_instr_addr_o, 32'd0);
    chk("rst_ex_taken", 32'(ex_br_taken_o), 32'd0);
    chk("rst_res_err", 32'(res_err_o), 32'd0);
    chk("rst_stat_br", 32'(stat_branches_o), 32'd0);
    chk("rst_stat_mp", 32'(stat_mispredicts_o), 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    // Fields: push{v,pc,taken,tgt}, res{v,pc,taken,tgt,comp}, expect{rdy, mp,redir, exv,addr,taken, err}
    tbl.push_back(V(1,'h100,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h104,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h108,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h10C,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h110,0,0,     0,0,0,0,0,              0, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h110,0,0,     1,'h100,0,0,0,          0, 0,0,       1,'h100,0,     0));
    tbl.push_back(V(1,'h110,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h104,0,0,0,          0, 0,0,       1,'h104,0,     0));
    tbl.push_back(V(1,'h114,0,0,     1,'h108,0,0,0,          1, 0,0,       1,'h108,0,     0));
    tbl.push_back(V(0,0,0,0,         1,'h10C,0,0,0,          1, 0,0,       1,'h10C,0,     0));
    tbl.push_back(V(0,0,0,0,         1,'h110,0,0,0,          1, 0,0,       1,'h110,0,     0));
    tbl.push_back(V(0,0,0,0,         1,'h114,0,0,0,          1, 0,0,       1,'h114,0,     0));
    tbl.push_back(V(1,'h200,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h200,1,'h180,0,      1, 1,'h180,   1,'h200,1,     0));
    tbl.push_back(V(1,'h250,0,0,     0,0,0,0,0,              0, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h250,0,0,0,          1, 0,0,       0,0,0,         1));
    tbl.push_back(V(1,'h300,1,'h340, 0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h304,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h308,0,0,     1,'h300,1,'h380,0,      1, 1,'h380,   1,'h300,1,     0));
    tbl.push_back(V(0,0,0,0,         0,0,0,0,0,              0, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h304,0,0,0,          1, 0,0,       0,0,0,         1));
    tbl.push_back(V(0,0,0,0,         1,'h308,0,0,0,          1, 0,0,       0,0,0,         1));
    tbl.push_back(V(1,'h400,1,'h500, 0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h400,1,'h500,0,      1, 0,0,       1,'h400,1,     0));
    tbl.push_back(V(1,'hFFFF_FFFE,1,'h10, 0,0,0,0,0,         1, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'hFFFF_FFFE,0,0,1,    1, 1,'h0,     1,'hFFFF_FFFE,0, 0));
    tbl.push_back(V(0,0,0,0,         0,0,0,0,0,              0, 0,0,       0,0,0,         0));
    tbl.push_back(V(1,'h600,1,'h700, 0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h600,0,0,0,          1, 1,'h604,   1,'h600,0,     0));
    tbl.push_back(V(0,0,0,0,         0,0,0,0,0,              0, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h123,0,0,0,          1, 0,0,       0,0,0,         1));
    tbl.push_back(V(1,'h700,0,0,     0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h704,0,0,0,          1, 0,0,       0,0,0,         1));
    tbl.push_back(V(0,0,0,0,         1,'h700,0,0,0,          1, 0,0,       1,'h700,0,     0));
    tbl.push_back(V(1,'h800,0,'h999, 0,0,0,0,0,              1, 0,0,       0,0,0,         0));
    tbl.push_back(V(0,0,0,0,         1,'h800,0,'h123,0,      1, 0,0,       1,'h800,0,     0));

    drive_idle();
    rst_i = 1'b1;
    exp_br = '0;
    exp_mp = '0;
    #1;
    chk_reset_state();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Asynchronous reset with three entries queued and non-zero stats/feedback.
    apply(V(1,'h900,0,0, 0,0,0,0,0, 1, 0,0, 0,0,0, 0));
    apply(V(1,'h904,0,0, 0,0,0,0,0, 1, 0,0, 0,0,0, 0));
    apply(V(1,'h908,0,0, 0,0,0,0,0, 1, 0,0, 0,0,0, 0));
    @(negedge clk_i);
    drive_idle();
    rst_i = 1'b1;
    #1;
    chk_reset_state();
    exp_br = '0;
    exp_mp = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    apply(V(0,0,0,0, 1,'h900,0,0,0, 1, 0,0, 0,0,0, 1));

    // Four mispredicts after reset: the 2-bit counters must stop at 3.
    for (int i = 0; i < 4; i++) begin
      pc = 32'hA00 + 32'(i) * 32'h10;
      apply(V(1,pc,0,0, 0,0,0,0,0,        1, 0,0,       0,0,0,  0));
      apply(V(0,0,0,0,  1,pc,1,'hB00,0,   1, 1,'hB00,   1,pc,1, 0));
      apply(V(0,0,0,0,  0,0,0,0,0,        0, 0,0,       0,0,0,  0));
    end
    chk("stat_mp_saturated", 32'(stat_mispredicts_o), 32'd3);
    chk("stat_br_saturated", 32'(stat_branches_o), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
